mem_bist: RTL

Built-in memory self-test initiator for the 6502 development memory system. It drives the memory's address, data and read/write-select lines. It runs a two-pass write/read-verify march over a fixed address range and reports pass/fail with the first failing location. It sits in place of the CPU on the memory bus during bring-up and is the hardware initiator for `mem`.

---
 rtl/mem_bist.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_bist.sv
// rtl/mem_bist.sv - two-pass write/read-verify march memory self-test initiator
//
// Drives the memory bus in place of the CPU during bring-up. Pass 0 writes
// P(a) = a[7:0] ^ a[15:8] ^ SEED to every address in [START_ADDR, END_ADDR]
// and reads it back; pass 1 does the same with ~P(a). Stops on the first
// mismatch and records its address, the expected byte and the byte read.
//
// Ports:
//   ph1            in   clock, all state changes on rising edge
//   reset          in   asynchronous active-low reset
//   start          in   one-cycle pulse, begins a test from IDLE or DONE
//   abort          in   return to IDLE at next edge (priority over all else)
//   address        out  memory address
//   read_write_sel out  1 = read, 0 = write
//   data_out       out  write data
//   data_oe        out  1 = drive data_out onto the bus
//   data_in        in   read data, valid during the RC cycle
//   busy           out  test in progress
//   done           out  test finished, held until next start
//   fail           out  mismatch found, valid with done
//   fail_addr      out  address of first mismatch
//   fail_expected  out  expected byte at fail_addr
//   fail_actual    out  byte read at fail_addr
module mem_bist #(
    parameter logic [15:0] START_ADDR = 16'h0000,
    parameter logic [15:0] END_ADDR   = 16'h00FF,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] address,
    output logic        read_write_sel,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [15:0] fail_addr,
    output logic [7:0]  fail_expected,
    output logic [7:0]  fail_actual
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_RA0,
        S_RC0,
        S_WR1,
        S_RA1,
        S_RC1,
        S_DONE
    } state_t;

    localparam logic        EMPTY_RANGE = (END_ADDR < START_ADDR);
    localparam logic [16:0] START_EXT   = {1'b0, START_ADDR};
    localparam logic [16:0] END_EXT     = {1'b0, END_ADDR};

    state_t      r_state;
    // One bit wider than the bus so a range ending at 16'hFFFF never aliases
    // back onto 16'h0000; the end test below fires before any increment.
    logic [16:0] r_addr;
    logic [15:0] r_address;
    logic        r_rw;
    logic [7:0]  r_data_out;
    logic        r_oe;
    logic        r_busy;
    logic        r_done;
    logic        r_fail;
    logic [15:0] r_fail_addr;
    logic [7:0]  r_fail_expected;
    logic [7:0]  r_fail_actual;

    logic [16:0] w_addr_next;
    logic        w_at_end;
    logic        w_pass1;
    logic [7:0]  w_expected;

    function automatic logic [7:0] pattern(input logic [15:0] a, input logic inv);
        logic [7:0] p;
        p = a[7:0] ^ a[15:8] ^ SEED;
        return inv ? ~p : p;
    endfunction

    assign w_addr_next = r_addr + 17'd1;
    assign w_at_end    = (r_addr == END_EXT);
    assign w_pass1     = (r_state == S_WR1) || (r_state == S_RA1) || (r_state == S_RC1);
    assign w_expected  = pattern(r_addr[15:0], w_pass1);

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_addr          <= 17'd0;
            r_address       <= 16'h0000;
            r_rw            <= 1'b1;
            r_data_out      <= 8'h00;
            r_oe            <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_fail          <= 1'b0;
            r_fail_addr     <= 16'h0000;
            r_fail_expected <= 8'h00;
            r_fail_actual   <= 8'h00;
        end else if (abort) begin
            // Release the bus and drop status; the failure record is kept
            // for post-mortem inspection.
            r_state <= S_IDLE;
            r_rw    <= 1'b1;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_done          <= 1'b0;
                        r_fail          <= 1'b0;
                        r_fail_addr     <= 16'h0000;
                        r_fail_expected <= 8'h00;
                        r_fail_actual   <= 8'h00;
                        if (EMPTY_RANGE) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_WR0;
                            r_addr     <= START_EXT;
                            r_address  <= START_ADDR;
                            r_data_out <= pattern(START_ADDR, 1'b0);
                            r_rw       <= 1'b0;
                            r_oe       <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                end

                S_WR0, S_WR1: begin
                    if (w_at_end) begin
                        r_state   <= w_pass1 ? S_RA1 : S_RA0;
                        r_addr    <= START_EXT;
                        r_address <= START_ADDR;
                        r_rw      <= 1'b1;
                        r_oe      <= 1'b0;
                    end else begin
                        r_addr     <= w_addr_next;
                        r_address  <= w_addr_next[15:0];
                        r_data_out <= pattern(w_addr_next[15:0], w_pass1);
                    end
                end

                S_RA0: r_state <= S_RC0;
                S_RA1: r_state <= S_RC1;

                S_RC0, S_RC1: begin
                    if (!r_fail && (data_in != w_expected)) begin
                        r_state         <= S_DONE;
                        r_fail          <= 1'b1;
                        r_fail_addr     <= r_addr[15:0];
                        r_fail_expected <= w_expected;
                        r_fail_actual   <= data_in;
                        r_done          <= 1'b1;
                        r_busy          <= 1'b0;
                    end else if (w_at_end) begin
                        if (w_pass1) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_WR1;
                            r_addr     <= START_EXT;
                            r_address  <= START_ADDR;
                            r_data_out <= pattern(START_ADDR, 1'b1);
                            r_rw       <= 1'b0;
                            r_oe       <= 1'b1;
                        end
                    end else begin
                        r_state   <= w_pass1 ? S_RA1 : S_RA0;
                        r_addr    <= w_addr_next;
                        r_address <= w_addr_next[15:0];
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_rw    <= 1'b1;
                    r_oe    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign address        = r_address;
    assign read_write_sel = r_rw;
    assign data_out       = r_data_out;
    assign data_oe        = r_oe;
    assign busy           = r_busy;
    assign done           = r_done;
    assign fail           = r_fail;
    assign fail_addr      = r_fail_addr;
    assign fail_expected  = r_fail_expected;
    assign fail_actual    = r_fail_actual;

endmodule
